// File: rtl/rr_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_sequencer
// Brief    : Round-robin owner sequencer. Grants are held until done, a dropped
//            request, or MAX_HOLD expiry, with one GAP cycle between grants.
//            Define RR_GRANT_SVA_EN to embed the protocol assertions.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_sequencer #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 preempt
);

  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [HW-1:0]   r_hold_cnt;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic            w_own_done;
  logic            w_own_req;
  logic            w_expired;
  logic            w_release;

  // Scan ptr+1, ptr+2, ... so the last owner has the lowest priority.
  always_comb begin
    logic [IDW-1:0] w_idx;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_own_done = done[gnt_id];
  assign w_own_req  = req[gnt_id];
  assign w_expired  = (r_hold_cnt == HW'(MAX_HOLD));
  assign w_release  = w_own_done | ~w_own_req | w_expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= IDW'(N - 1);
      r_hold_cnt <= '0;
      gnt        <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      preempt    <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_found) begin
            r_state    <= S_GRANT;
            gnt        <= ONE_HOT0 << w_win;
            gnt_id     <= w_win;
            busy       <= 1'b1;
            r_hold_cnt <= HW'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state    <= S_GAP;
            gnt        <= '0;
            busy       <= 1'b0;
            r_ptr      <= gnt_id;
            r_hold_cnt <= '0;
            // Only a pure budget expiry counts as preemption.
            preempt    <= w_expired & w_own_req & ~w_own_done;
          end else if (r_hold_cnt != {HW{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RR_GRANT_SVA_EN
  localparam int FAIR_BOUND = (N - 1) * (MAX_HOLD + 1) + 1;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(gnt))
    else $error("gnt not one-hot0: gnt_id=%0d req=%b", gnt_id, $sampled(req));

  a_gnt_had_req: assert property (@(posedge clk) disable iff (!reset_n)
    (gnt & ~$past(req)) == '0)
    else $error("gnt without prior req: gnt_id=%0d req=%b", gnt_id, $sampled(req));

  a_gap_after_grant: assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == S_GRANT && w_release) |=> (gnt == '0 && r_state == S_GAP))
    else $error("missing GAP: gnt_id=%0d req=%b", gnt_id, $sampled(req));

  a_hold_bound: assert property (@(posedge clk) disable iff (!reset_n)
    r_hold_cnt <= HW'(MAX_HOLD))
    else $error("hold_cnt overflow: gnt_id=%0d req=%b", gnt_id, $sampled(req));

  for (genvar i = 0; i < N; i++) begin : g_fair
    logic [15:0] r_wait;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wait <= '0;
      end else if (req[i] && !gnt[i]) begin
        r_wait <= r_wait + 16'd1;
      end else begin
        r_wait <= '0;
      end
    end

    a_fair: assert property (@(posedge clk) disable iff (!reset_n)
      int'(r_wait) <= FAIR_BOUND)
      else $error("starvation: gnt_id=%0d req=%b", gnt_id, $sampled(req));
  end
`else
  // Default build carries no checking logic.
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_sequencer
// Brief    : Directed self-checking bench for rr_grant_sequencer (N=4, MAX_HOLD=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_sequencer;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_grant_sequencer #(.N(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111; done = 4'b0000; reset_n = 1'b0;
    step(); step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
    reset_n = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got=%b exp=%b", gnt, 4'b0001); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy got=%b exp=1", busy); end
    req = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_drop_gap got=%b exp=%b", gnt, 4'b0000); end
    step();
  endtask

  task automatic test_single();
    // ptr=0 here: scanning 1,2,3,0 still picks the only requester 0
    req = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_hold c%0d got=%b exp=%b", c, gnt, 4'b0001); end
    end
    done = 4'b0001;
    step();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_gap gnt=%b busy=%b exp=0000/0", gnt, busy); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL single_gap_preempt got=%b exp=0", preempt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL single_gap_id got=%0d exp=0", gnt_id); end
    req = 4'b0000; done = 4'b0000;
    step();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_idle gnt=%b busy=%b exp=0000/0", gnt, busy); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    step();
    for (int s = 0; s < 5; s++) begin
      logic [3:0] eg;
      eg = 4'b0001 << exp_seq[s];
      checks++; if (gnt !== eg || gnt_id !== exp_seq[s]) begin errors++; $display("FAIL fair_g1 s%0d gnt=%b id=%0d exp=%b/%0d", s, gnt, gnt_id, eg, exp_seq[s]); end
      step();
      checks++; if (gnt !== eg) begin errors++; $display("FAIL fair_g2 s%0d got=%b exp=%b", s, gnt, eg); end
      done = eg;
      step();
      checks++; if (gnt !== 4'b0000 || preempt !== 1'b0) begin errors++; $display("FAIL fair_gap s%0d gnt=%b preempt=%b exp=0000/0", s, gnt, preempt); end
      done = 4'b0000;
      if (s == 4) req = 4'b0000;
      step();
    end
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL fair_idle gnt=%b busy=%b exp=0000/0", gnt, busy); end
  endtask

  task automatic test_preempt();
    // ptr=0 after the fairness run; 2 is the only requester
    req = 4'b0100;
    step();
    for (int c = 1; c <= 8; c++) begin
      checks++; if (gnt !== 4'b0100 || preempt !== 1'b0) begin errors++; $display("FAIL pre_hold c%0d gnt=%b preempt=%b exp=0100/0", c, gnt, preempt); end
      step();
    end
    checks++; if (gnt !== 4'b0000 || preempt !== 1'b1) begin errors++; $display("FAIL pre_gap gnt=%b preempt=%b exp=0000/1", gnt, preempt); end
    step();
    checks++; if (gnt !== 4'b0100 || preempt !== 1'b0) begin errors++; $display("FAIL pre_regrant gnt=%b preempt=%b exp=0100/0", gnt, preempt); end
    // Owner 2 keeps the budget; requester 1 joins and must win after expiry.
    req = 4'b0110;
    for (int c = 2; c <= 8; c++) step();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL pre2_last got=%b exp=%b", gnt, 4'b0100); end
    step();
    checks++; if (gnt !== 4'b0000 || preempt !== 1'b1) begin errors++; $display("FAIL pre2_gap gnt=%b preempt=%b exp=0000/1", gnt, preempt); end
    step();
    checks++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin errors++; $display("FAIL pre2_next gnt=%b id=%0d exp=0010/1", gnt, gnt_id); end
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_async_reset();
    // ptr=1: requester 1 alone wins
    req = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ar_pre got=%b exp=%b", gnt, 4'b0010); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL ar_immediate gnt=%b busy=%b exp=0000/0", gnt, busy); end
    req = 4'b1010;
    step();
    reset_n = 1'b1;
    step();
    checks++; if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin errors++; $display("FAIL ar_restart gnt=%b id=%0d exp=0010/1", gnt, gnt_id); end
  endtask

  task automatic test_corner();
    // Owner 1 holds with req=1010; done from non-owner 2 must be ignored
    done = 4'b0100;
    step();
    checks++; if (gnt !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL corner_ignore1 gnt=%b busy=%b exp=0010/1", gnt, busy); end
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL corner_ignore2 got=%b exp=%b", gnt, 4'b0010); end
    req = 4'b1000; done = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0000 || preempt !== 1'b0) begin errors++; $display("FAIL corner_gap gnt=%b preempt=%b exp=0000/0", gnt, preempt); end
    done = 4'b0000;
    step();
    checks++; if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin errors++; $display("FAIL corner_next gnt=%b id=%0d exp=1000/3", gnt, gnt_id); end
    req = 4'b0000;
    step(); step();
  endtask

  initial begin
    reset_n = 1'b0; req = 4'b0000; done = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_preempt();
    test_async_reset();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
